// File: rtl/spi_lb_pkg.sv
// Shared defaults, master state encoding and counter-width helpers for the
// SPI loopback master/slave pair.
package spi_lb_pkg;

    localparam int DATA_W_DEF    = 12;
    localparam int SCLK_HALF_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        END  = 2'd2
    } mst_state_t;

    function automatic int bcnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    function automatic int div_w(input int sclk_half);
        return $clog2(sclk_half);
    endfunction

    localparam int BCNT_W = bcnt_w(DATA_W_DEF);
    localparam int DIV_W  = div_w(SCLK_HALF_DEF);

endpackage

// File: rtl/spi_lb_master.sv
// SPI master: accepts a word while idle and shifts it out LSB first on mosi,
// changing data on sclk falling edges so the slave samples on rising edges.
module spi_lb_master
    import spi_lb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SCLK_HALF = SCLK_HALF_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_data,
    input  logic [DATA_W-1:0] din,
    output logic              cs,
    output logic              sclk,
    output logic              mosi
);

    localparam int BW = bcnt_w(DATA_W);
    localparam int DW = div_w(SCLK_HALF);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    mst_state_t        state;
    logic [DW-1:0]     div;
    logic [BW-1:0]     bitcnt;
    logic [DATA_W-1:0] tx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cs     <= 1'b1;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            div    <= '0;
            bitcnt <= '0;
            tx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cs   <= 1'b1;
                    sclk <= 1'b0;
                    if (new_data) begin
                        tx     <= din;
                        mosi   <= din[0];
                        cs     <= 1'b0;
                        div    <= '0;
                        bitcnt <= '0;
                        state  <= XFER;
                    end
                end
                XFER: begin
                    if (div == DIV_LAST) begin
                        div  <= '0;
                        sclk <= ~sclk;
                        // sclk currently high: this wrap is a falling toggle
                        if (sclk) begin
                            tx     <= {1'b0, tx[DATA_W-1:1]};
                            mosi   <= tx[1];
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == BIT_LAST) begin
                                cs    <= 1'b1;
                                state <= END;
                            end
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                END: begin
                    cs    <= 1'b1;
                    sclk  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/spi_lb_slave.sv
// SPI slave in the clk domain: detects sclk rising edges while cs is low,
// assembles the LSB-first word and publishes it with a one-cycle done pulse.
module spi_lb_slave
    import spi_lb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    localparam int BW = bcnt_w(DATA_W);
    localparam logic [BW-1:0] CNT_FULL = BW'(DATA_W);

    logic              sclk_q;
    logic [BW-1:0]     count;
    logic [DATA_W-1:0] rx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_q <= 1'b0;
            count  <= '0;
            rx     <= '0;
            done   <= 1'b0;
            dout   <= '0;
        end else begin
            sclk_q <= sclk;
            done   <= 1'b0;
            // a full word is published even if cs has already risen
            if (count == CNT_FULL) begin
                dout  <= rx;
                done  <= 1'b1;
                count <= '0;
            end else if (cs) begin
                count <= '0;
            end else if (!sclk_q && sclk) begin
                rx    <= {mosi, rx[DATA_W-1:1]};
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_loopback_top.sv
// SPI loopback: master and slave joined by internal cs/sclk/mosi wires.
module spi_loopback_top
    import spi_lb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SCLK_HALF = SCLK_HALF_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_data,
    input  logic [DATA_W-1:0] din,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    logic cs;
    logic sclk;
    logic mosi;

    spi_lb_master #(.DATA_W(DATA_W), .SCLK_HALF(SCLK_HALF)) u_master (
        .clk      (clk),
        .reset    (reset),
        .new_data (new_data),
        .din      (din),
        .cs       (cs),
        .sclk     (sclk),
        .mosi     (mosi)
    );

    spi_lb_slave #(.DATA_W(DATA_W)) u_slave (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .sclk  (sclk),
        .mosi  (mosi),
        .done  (done),
        .dout  (dout)
    );

endmodule

// File: tb/tb_spi_loopback_top.sv
// Directed bench for spi_loopback_top: reset, single words, LSB-first wire
// order, continuous requests, mid-transfer din change and mid-transfer reset.
module tb_spi_loopback_top;
    import spi_lb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        new_data = 1'b0;
    logic [11:0] din = '0;
    logic        done;
    logic [11:0] dout;

    int nchk = 0;
    int npass = 0;
    int cyc = 0;
    int ndone = 0;
    int last_done_cyc = 0;
    logic [11:0] mosi_sr = '0;

    spi_loopback_top dut (
        .clk      (clk),
        .reset    (reset),
        .new_data (new_data),
        .din      (din),
        .done     (done),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (done) begin
            ndone = ndone + 1;
            last_done_cyc = cyc;
        end
    end

    // independent capture of the wire-level bit order at each sclk rise
    always @(posedge dut.sclk)
        if (!dut.cs) mosi_sr <= {dut.mosi, mosi_sr[11:1]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int start;
        bit seen;
        start = ndone;
        seen = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (ndone > start) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic send_one(input string tag, input logic [11:0] w);
        int s;
        s = ndone;
        din = w;
        new_data = 1'b1;
        tick(1);
        new_data = 1'b0;
        wait_done(tag, 110);
        chk({tag, "_dout"}, 32'(dout), 32'(w));
        chk({tag, "_lsb_first"}, 32'(mosi_sr), 32'(w));
        chk({tag, "_ndone"}, 32'(ndone - s), 32'd1);
        tick(4);
    endtask

    initial begin
        int c0, s, t1, t2, t3;

        // reset
        tick(2);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dout", 32'(dout), 32'h000);
        chk("rst_cs", 32'(dut.cs), 32'd1);
        chk("rst_sclk", 32'(dut.sclk), 32'd0);
        reset = 1'b1;
        tick(3);
        chk("idle_cs", 32'(dut.cs), 32'd1);
        chk("idle_sclk", 32'(dut.sclk), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // basic: request held 10 cycles yields a single transfer
        s = ndone;
        din = 12'd791;
        new_data = 1'b1;
        c0 = cyc;
        tick(10);
        new_data = 1'b0;
        wait_done("basic", 100);
        chk("basic_lat_le100", 32'((last_done_cyc - c0) <= 100), 32'd1);
        chk("basic_dout", 32'(dout), 32'd791);
        tick(200);
        chk("basic_hold_dout", 32'(dout), 32'd791);
        chk("basic_ndone", 32'(ndone - s), 32'd1);

        // patterns
        send_one("p_fff", 12'hFFF);
        send_one("p_000", 12'h000);
        send_one("p_a5a", 12'hA5A);
        send_one("p_5a5", 12'h5A5);

        // continuous request
        din = 12'h123;
        new_data = 1'b1;
        wait_done("hold1", 110);
        t1 = last_done_cyc;
        chk("hold1_dout", 32'(dout), 32'h123);
        wait_done("hold2", 110);
        t2 = last_done_cyc;
        chk("hold2_dout", 32'(dout), 32'h123);
        wait_done("hold3", 110);
        t3 = last_done_cyc;
        new_data = 1'b0;
        chk("hold3_dout", 32'(dout), 32'h123);
        chk("hold_gap12", 32'(t2 - t1), 32'd98);
        chk("hold_gap23", 32'(t3 - t2), 32'd98);
        tick(10);

        // din change mid-transfer is ignored
        din = 12'h317;
        new_data = 1'b1;
        tick(1);
        new_data = 1'b0;
        tick(19);
        din = 12'h0FF;
        wait_done("mid", 110);
        chk("mid_dout", 32'(dout), 32'h317);
        chk("mid_lsb_first", 32'(mosi_sr), 32'h317);
        tick(4);

        // reset mid-transfer
        din = 12'hABC;
        new_data = 1'b1;
        tick(1);
        new_data = 1'b0;
        tick(39);
        reset = 1'b0;
        tick(1);
        chk("rmid_dout", 32'(dout), 32'h000);
        chk("rmid_state", 32'(dut.u_master.state), 32'(IDLE));
        chk("rmid_cs", 32'(dut.cs), 32'd1);
        reset = 1'b1;
        s = ndone;
        tick(120);
        chk("rmid_no_done", 32'(ndone - s), 32'd0);
        chk("rmid_dout_after", 32'(dout), 32'h000);
        send_one("after_rst", 12'h321);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/spi_loopback_top.md
Name: spi_loopback_top

Overview:
- Self-contained SPI loopback: an SPI master serialises a 12-bit word onto internal cs/sclk/mosi wires, and an SPI slave on the same wires deserialises it.
- The recovered word is presented on dout with a one-cycle done pulse.
- Used as a protocol smoke block and as a reference pairing for the master and slave.
- Single clock domain; sclk is a divided, internally generated signal, not a second clock.

Parameters:
- DATA_W, 12, word width in bits.
- SCLK_HALF, 4, sclk half-period in clk cycles; sclk period = 2*SCLK_HALF clk cycles; legal range ≥2.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- new_data  input  1  transfer request, level-sensitive, sampled only while the master is idle.
- din  input  DATA_W  word to transmit, captured when the request is accepted.
- done  output  1  single-cycle pulse: dout has just been updated.
- dout  output  DATA_W  last word received by the slave; holds until the next completed transfer.

Behaviour:
- Reset (reset=0, asynchronous):
  - Master in IDLE, cs=1, sclk=0, mosi=0, bit counter=0.
  - Slave shift register and counter = 0.
  - Outputs: done=0, dout=0.
  - Takes effect immediately, including mid-transfer; the partial word is discarded and dout is not updated.
- Master FSM: IDLE -> XFER -> END -> IDLE.
  - IDLE: sclk=0, cs=1. If new_data=1 on a clk edge, latch din into tx shift register, drive cs=0, mosi=din[0], clear divider and bit counter, go to XFER.
  - XFER: divider counts 0..SCLK_HALF-1 and toggles sclk on wrap; the first toggle is rising.
    - On each sclk falling toggle, shift tx right and drive the next bit on mosi; LSB first.
    - After the DATA_W-th falling toggle, go to END.
  - END: one clk cycle; cs=1, sclk=0; then IDLE.
  - new_data and din are ignored outside IDLE; changing din mid-transfer has no effect.
  - If new_data is still 1 on return to IDLE, a new transfer with the current din starts.
- Slave (clk domain, registers previous sclk):
  - Rising sclk detect = sclk_q==0 && sclk==1 while cs==0.
  - On each detected edge: rx <= {mosi, rx[DATA_W-1:1]} (LSB-first), count++.
  - When count reaches DATA_W: dout <= assembled word on the next clk edge, done=1 for exactly that one cycle, count <= 0.
  - cs=1 clears count without touching dout; a short, aborted frame produces no done.
- Timing:
  - mosi is stable for SCLK_HALF clk cycles before each sampling edge.
  - done asserts no later than 2*SCLK_HALF*DATA_W + 4 clk cycles after the accepting clk edge; with defaults, ≤100 cycles.
  - Minimum gap between done pulses in continuous operation is 2*SCLK_HALF*DATA_W + 2 cycles.
- Width rules: no arithmetic on data; counters sized $clog2(DATA_W+1) and $clog2(SCLK_HALF).

Decomposition:
- Package spi_lb_pkg:
  - DATA_W and SCLK_HALF defaults.
  - Master state enum {IDLE, XFER, END}.
  - Counter width localparams.
- Sub-modules:
  - spi_lb_master: FSM, divider, tx shifter.
  - spi_lb_slave: edge detect, rx shifter, done/dout.
- Top-level only wires cs, sclk and mosi between the two sub-modules.

Test Plan:
- Reset: assert reset=0 for 2 cycles, release -> done=0, dout=0x000; internal cs=1, sclk=0 while idle with new_data=0.
- Basic: din=791 (0x317), new_data=1 for 10 cycles then 0 -> exactly one done pulse within 100 cycles, dout=791, held for ≥200 further cycles.
- Patterns: back-to-back single requests with 0xFFF, 0x000, 0xA5A, 0x5A5 -> dout matches each din, one done per word; check LSB-first order on mosi.
- Hold: new_data held high continuously with din=0x123 -> repeated transfers with done spaced 98 cycles apart, dout=0x123 each time.
- Mid-transfer changes: din changed to 0x0FF after 20 cycles of a 0x317 transfer -> dout=0x317.
- Reset mid-transfer: pulse reset=0 after 40 cycles of a 0xABC transfer -> no done, dout=0, master IDLE; next request for 0x321 yields dout=0x321.
